// File: rtl/window_pkg.sv
// Shared definitions for the windowing-stage frame sequencer:
// FSM encodings, default frame geometry and the symmetric coefficient fold.
package window_pkg;

  localparam int N_SAMPLES_DEFAULT = 2048;
  localparam int ADDR_W_DEFAULT    = 11;
  localparam int DATA_W            = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_STALL      = 3'd3,
    ST_DRAIN      = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // The window is symmetric, so the ROM stores only the first half.
  function automatic int fold_coef(input int idx, input int n);
    if (idx < (n / 32'sd2)) begin
      return idx;
    end else begin
      return n - 32'sd1 - idx;
    end
  endfunction

endpackage

// File: rtl/window_pipe_track.sv
// Valid/pair-index delay line that mirrors the RAM -> multiplier -> buffer
// datapath and produces the downstream strobes and write address.
module window_pipe_track
  import window_pkg::*;
#(
  parameter int RD_LAT    = 2,
  parameter int TOTAL_LAT = 3,
  parameter int KW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue,
  input  logic [KW-1:0] issue_k,
  output logic          mult_en,
  output logic          wr_en,
  output logic          first,
  output logic [KW:0]   wr_addr,
  output logic          empty
);

  logic [TOTAL_LAT-1:0] vld_r;
  logic [KW-1:0]        k_r [TOTAL_LAT];

  // Shift valid bits and pair indices one stage per cycle; idle stages carry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= {TOTAL_LAT{1'b0}};
      for (int i = 0; i < TOTAL_LAT; i++) begin
        k_r[i] <= {KW{1'b0}};
      end
    end else begin
      vld_r  <= {vld_r[TOTAL_LAT-2:0], issue};
      k_r[0] <= issue ? issue_k : {KW{1'b0}};
      for (int i = 1; i < TOTAL_LAT; i++) begin
        k_r[i] <= k_r[i-1];
      end
    end
  end

  assign mult_en = vld_r[RD_LAT-1];
  assign wr_en   = vld_r[TOTAL_LAT-1];
  assign wr_addr = {k_r[TOTAL_LAT-1], 1'b0};
  assign first   = vld_r[TOTAL_LAT-1] && (k_r[TOTAL_LAT-1] == {KW{1'b0}});
  // Nothing is still ahead of the write stage, so the write now on wr_en is the last.
  assign empty   = ~|vld_r[TOTAL_LAT-2:0];

endmodule

// File: rtl/window_sequencer.sv
// Frame controller for the windowing datapath: walks one frame of sample pairs
// through sample RAM, coefficient ROM/multiplier and the FFT input buffer.
module window_sequencer
  import window_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int RAM_LAT   = 2,
  parameter int MULT_LAT  = 1,
  parameter int ISSUE_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              frame_ready,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              next,
  output logic [2:0]        state,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-2:0] coef_addr_a,
  output logic [ADDR_W-2:0] coef_addr_b,
  output logic              mult_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int KW    = ADDR_W - 1;
  localparam int GAP_W = 4;
  localparam logic [KW-1:0]    LAST_K     = KW'(N_SAMPLES / 32'sd2 - 32'sd1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP - 32'sd1);

  state_t            state_r;
  state_t            state_s;
  logic [KW-1:0]     k_r;
  logic [GAP_W-1:0]  gap_r;
  logic              gap_zero_s;
  logic              issue_s;
  logic              last_issue_s;
  logic              pipe_empty_s;

  assign gap_zero_s   = (gap_r == {GAP_W{1'b0}});
  assign issue_s      = (state_r == ST_ISSUE) && gap_zero_s && out_ready;
  assign last_issue_s = issue_s && (k_r == LAST_K);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; out_ready only matters at an issue slot.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_WAIT_FRAME;
        else       state_s = ST_IDLE;
      end
      ST_WAIT_FRAME: begin
        if (frame_ready) state_s = ST_ISSUE;
        else             state_s = ST_WAIT_FRAME;
      end
      ST_ISSUE: begin
        if (gap_zero_s && !out_ready) state_s = ST_STALL;
        else if (last_issue_s)        state_s = ST_DRAIN;
        else                          state_s = ST_ISSUE;
      end
      ST_STALL: begin
        if (out_ready) state_s = ST_ISSUE;
        else           state_s = ST_STALL;
      end
      ST_DRAIN: begin
        if (pipe_empty_s) state_s = ST_DONE;
        else              state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Pair index and issue-gap counter; the gap is zero on every entry to ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_r   <= {KW{1'b0}};
      gap_r <= {GAP_W{1'b0}};
    end else begin
      if (state_r == ST_WAIT_FRAME) begin
        k_r <= {KW{1'b0}};
      end else if (issue_s) begin
        k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
      end
      if (state_r != ST_ISSUE) begin
        gap_r <= {GAP_W{1'b0}};
      end else if (issue_s) begin
        gap_r <= GAP_RELOAD;
      end else if (!gap_zero_s) begin
        gap_r <= gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read strobe and addresses, held at zero between issues.
  always_comb begin
    rd_en       = issue_s;
    rd_addr_a   = {ADDR_W{1'b0}};
    rd_addr_b   = {ADDR_W{1'b0}};
    coef_addr_a = {KW{1'b0}};
    coef_addr_b = {KW{1'b0}};
    if (issue_s) begin
      rd_addr_a   = {k_r, 1'b0};
      rd_addr_b   = {k_r, 1'b1};
      coef_addr_a = KW'(fold_coef(int'({k_r, 1'b0}), N_SAMPLES));
      coef_addr_b = KW'(fold_coef(int'({k_r, 1'b1}), N_SAMPLES));
    end else begin
      rd_addr_a   = {ADDR_W{1'b0}};
      rd_addr_b   = {ADDR_W{1'b0}};
      coef_addr_a = {KW{1'b0}};
      coef_addr_b = {KW{1'b0}};
    end
  end

  assign busy  = (state_r != ST_IDLE);
  assign done  = (state_r == ST_DONE);
  assign state = state_r;

  window_pipe_track #(
    .RD_LAT    (RAM_LAT),
    .TOTAL_LAT (RAM_LAT + MULT_LAT),
    .KW        (KW)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .issue   (issue_s),
    .issue_k (k_r),
    .mult_en (mult_en),
    .wr_en   (wr_en),
    .first   (next),
    .wr_addr (wr_addr),
    .empty   (pipe_empty_s)
  );

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench: default frame, backpressure, gating and reset on one instance,
// coefficient folding at N=16 and back-to-back frames with ISSUE_GAP=1.
module tb_window_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- DUT A: defaults ----------------
  logic        a_reset, a_start, a_frame_ready, a_out_ready;
  logic        a_busy, a_done, a_next, a_rd_en, a_mult_en, a_wr_en;
  logic [2:0]  a_state;
  logic [10:0] a_rd_addr_a, a_rd_addr_b, a_wr_addr;
  logic [9:0]  a_coef_a, a_coef_b;

  window_sequencer u_a (
    .clk(clk), .reset(a_reset), .start(a_start), .frame_ready(a_frame_ready),
    .out_ready(a_out_ready), .busy(a_busy), .done(a_done), .next(a_next),
    .state(a_state), .rd_en(a_rd_en), .rd_addr_a(a_rd_addr_a), .rd_addr_b(a_rd_addr_b),
    .coef_addr_a(a_coef_a), .coef_addr_b(a_coef_b), .mult_en(a_mult_en),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr)
  );

  // ---------------- DUT B: N_SAMPLES=16 ----------------
  logic        b_reset, b_start, b_frame_ready, b_out_ready;
  logic        b_busy, b_done, b_next, b_rd_en, b_mult_en, b_wr_en;
  logic [2:0]  b_state;
  logic [3:0]  b_rd_addr_a, b_rd_addr_b, b_wr_addr;
  logic [2:0]  b_coef_a, b_coef_b;

  window_sequencer #(.N_SAMPLES(16), .ADDR_W(4)) u_b (
    .clk(clk), .reset(b_reset), .start(b_start), .frame_ready(b_frame_ready),
    .out_ready(b_out_ready), .busy(b_busy), .done(b_done), .next(b_next),
    .state(b_state), .rd_en(b_rd_en), .rd_addr_a(b_rd_addr_a), .rd_addr_b(b_rd_addr_b),
    .coef_addr_a(b_coef_a), .coef_addr_b(b_coef_b), .mult_en(b_mult_en),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr)
  );

  // ---------------- DUT C: ISSUE_GAP=1 ----------------
  logic        c_reset, c_start, c_frame_ready, c_out_ready;
  logic        c_busy, c_done, c_next, c_rd_en, c_mult_en, c_wr_en;
  logic [2:0]  c_state;
  logic [10:0] c_rd_addr_a, c_rd_addr_b, c_wr_addr;
  logic [9:0]  c_coef_a, c_coef_b;

  window_sequencer #(.ISSUE_GAP(1)) u_c (
    .clk(clk), .reset(c_reset), .start(c_start), .frame_ready(c_frame_ready),
    .out_ready(c_out_ready), .busy(c_busy), .done(c_done), .next(c_next),
    .state(c_state), .rd_en(c_rd_en), .rd_addr_a(c_rd_addr_a), .rd_addr_b(c_rd_addr_b),
    .coef_addr_a(c_coef_a), .coef_addr_b(c_coef_b), .mult_en(c_mult_en),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr)
  );

  // ---------------- monitors (sampled on the active edge, before outputs move) ----------------
  int          a_wr_cnt = 0, a_next_cnt = 0, a_done_cnt = 0, a_seq_err = 0;
  int          a_clr = 0, a_clr_seen = 0;
  int          a_last_wr_cyc = 0, a_done_cyc = 0, a_first_rd_cyc = 0;
  logic [9:0]  a_exp_k = 10'd0;
  logic [9:0]  a_last_coef_a = 10'd0, a_last_coef_b = 10'd0;
  logic [10:0] a_last_rd_addr = 11'd0;

  always @(posedge clk) begin
    cyc++;
    if (a_clr != a_clr_seen) begin
      a_exp_k    = 10'd0;
      a_clr_seen = a_clr;
    end
    if (a_wr_en) begin
      if (a_wr_addr !== {a_exp_k, 1'b0}) a_seq_err++;
      a_exp_k++;
      a_wr_cnt++;
      a_last_wr_cyc = cyc;
    end
    if (a_next) a_next_cnt++;
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    if (a_rd_en) begin
      a_last_rd_addr = a_rd_addr_a;
      a_last_coef_a  = a_coef_a;
      a_last_coef_b  = a_coef_b;
      if (a_rd_addr_a == 11'd0) a_first_rd_cyc = cyc;
    end
  end

  int         c_wr_cnt = 0, c_next_cnt = 0, c_done_cnt = 0, c_seq_err = 0;
  int         c_rd_cnt = 0, c_hole = 0;
  logic [9:0] c_exp_k = 10'd0;

  always @(posedge clk) begin
    if (c_wr_en) begin
      if (c_wr_addr !== {c_exp_k, 1'b0}) c_seq_err++;
      c_exp_k++;
      c_wr_cnt++;
    end
    if (c_next) c_next_cnt++;
    if (c_done) c_done_cnt++;
    if (c_rd_en) c_rd_cnt++;
    if (c_state == 3'd2 && !c_rd_en) c_hole++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_done(input int bound);
    int n;
    n = 0;
    while (a_done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("a_done_reached", 32'(a_done), 32'd1);
  endtask

  initial begin
    int base_wr, base_next, base_done, bk, n;
    logic b_done_seen;
    logic [2:0] fold_a [8];
    logic [2:0] fold_b [8];
    fold_a = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7, 3'd5, 3'd3, 3'd1};
    fold_b = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd6, 3'd4, 3'd2, 3'd0};

    a_reset = 1'b1; a_start = 1'b0; a_frame_ready = 1'b0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_frame_ready = 1'b0; b_out_ready = 1'b0;
    c_reset = 1'b1; c_start = 1'b0; c_frame_ready = 1'b0; c_out_ready = 1'b0;
    tick(); tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

    // Reset state
    check("reset_ctrl", 32'({a_busy, a_done, a_next, a_rd_en, a_mult_en, a_wr_en, a_state}), 32'd0);
    check("reset_rd_addr", 32'({a_rd_addr_a, a_rd_addr_b}), 32'd0);
    check("reset_coef_wr", 32'({a_coef_a, a_coef_b, a_wr_addr}), 32'd0);

    // Nominal frame
    base_wr = a_wr_cnt; base_next = a_next_cnt; base_done = a_done_cnt;
    a_clr++;
    a_start = 1'b1; a_frame_ready = 1'b1; a_out_ready = 1'b1;
    tick();
    check("nom_wait_one_cycle", 32'(a_state), 32'd1);
    a_start = 1'b0;
    tick();
    check("nom_issue_state", 32'(a_state), 32'd2);
    check("nom_first_rd_en", 32'(a_rd_en), 32'd1);
    check("nom_first_rd_addr", 32'({a_rd_addr_a, a_rd_addr_b}), 32'({11'd0, 11'd1}));
    check("nom_first_coef", 32'({a_coef_a, a_coef_b}), 32'({10'd0, 10'd1}));
    tick();
    check("nom_gap_cycle", 32'({a_rd_en, a_mult_en, a_wr_en}), 32'd0);
    tick();
    check("nom_mult_en_lat2", 32'(a_mult_en), 32'd1);
    check("nom_second_rd", 32'({a_rd_en, a_rd_addr_a}), 32'({1'b1, 11'd2}));
    tick();
    check("nom_wr_next_lat3", 32'({a_wr_en, a_next, a_wr_addr}), 32'({1'b1, 1'b1, 11'd0}));
    wait_a_done(3000);
    tick();
    check("nom_idle_after_done", 32'({a_busy, a_state}), 32'd0);
    check("nom_write_count", 32'(a_wr_cnt - base_wr), 32'd1024);
    check("nom_next_count", 32'(a_next_cnt - base_next), 32'd1);
    check("nom_done_count", 32'(a_done_cnt - base_done), 32'd1);
    check("nom_last_rd_addr", 32'(a_last_rd_addr), 32'd2046);
    check("nom_last_coef", 32'({a_last_coef_a, a_last_coef_b}), 32'({10'd1, 10'd0}));
    check("nom_frame_length", 32'(a_done_cyc - a_first_rd_cyc), 32'd2050);
    check("nom_done_after_last_wr", 32'(a_done_cyc - a_last_wr_cyc), 32'd1);
    check("nom_wr_sequence", 32'(a_seq_err), 32'd0);

    // Backpressure at k=100
    base_wr = a_wr_cnt; base_done = a_done_cnt;
    a_clr++;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (!(a_rd_en === 1'b1 && a_rd_addr_a == 11'd198) && n < 1000) begin
      tick();
      n++;
    end
    check("bp_reach_k99", 32'(a_rd_addr_a), 32'd198);
    tick();
    a_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_no_rd_while_low", 32'(a_rd_en), 32'd0);
      tick();
    end
    check("bp_stall_state", 32'(a_state), 32'd3);
    check("bp_inflight_written", 32'(a_wr_cnt - base_wr), 32'd100);
    a_out_ready = 1'b1;
    tick();
    check("bp_resume_k100", 32'({a_state, a_rd_en, a_rd_addr_a}), 32'({3'd2, 1'b1, 11'd200}));
    wait_a_done(3000);
    tick();
    check("bp_write_count", 32'(a_wr_cnt - base_wr), 32'd1024);
    check("bp_done_count", 32'(a_done_cnt - base_done), 32'd1);
    check("bp_wr_sequence", 32'(a_seq_err), 32'd0);

    // Frame gating, start while busy ignored
    a_clr++;
    a_frame_ready = 1'b0;
    a_start = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      check("gate_wait_frame", 32'({a_state, a_busy, a_rd_en}), 32'({3'd1, 1'b1, 1'b0}));
      tick();
    end
    a_start = 1'b0;
    a_frame_ready = 1'b1;
    tick();
    check("gate_issue_begins", 32'({a_state, a_rd_en, a_rd_addr_a}), 32'({3'd2, 1'b1, 11'd0}));
    a_frame_ready = 1'b0;

    // Reset at k=300
    n = 0;
    while (!(a_rd_en === 1'b1 && a_rd_addr_a == 11'd600) && n < 1000) begin
      tick();
      n++;
    end
    check("rst_reach_k300", 32'(a_rd_addr_a), 32'd600);
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    check("rst_ctrl_zero", 32'({a_busy, a_done, a_next, a_rd_en, a_mult_en, a_wr_en, a_state}), 32'd0);
    check("rst_addr_zero", 32'({a_rd_addr_a, a_rd_addr_b, a_wr_addr}), 32'd0);
    base_wr = a_wr_cnt; base_done = a_done_cnt; base_next = a_next_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("rst_no_more_activity", 32'((a_wr_cnt - base_wr) + (a_done_cnt - base_done) + (a_next_cnt - base_next)), 32'd0);
    a_clr++;
    base_wr = a_wr_cnt;
    a_start = 1'b1; a_frame_ready = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    check("rst_restart_k0", 32'({a_state, a_rd_en, a_rd_addr_a}), 32'({3'd2, 1'b1, 11'd0}));
    wait_a_done(3000);
    tick();
    check("rst_restart_writes", 32'(a_wr_cnt - base_wr), 32'd1024);

    // Coefficient folding at N=16
    bk = 0;
    b_done_seen = 1'b0;
    b_start = 1'b1; b_frame_ready = 1'b1; b_out_ready = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 80 && !b_done_seen; i++) begin
      if (b_rd_en === 1'b1 && bk < 8) begin
        check("fold_coef_a", 32'(b_coef_a), 32'(fold_a[bk]));
        check("fold_coef_b", 32'(b_coef_b), 32'(fold_b[bk]));
        bk++;
      end
      if (b_done === 1'b1) b_done_seen = 1'b1;
      tick();
    end
    check("fold_pair_count", 32'(bk), 32'd8);
    check("fold_done_seen", 32'(b_done_seen), 32'd1);

    // ISSUE_GAP=1, start held high for two frames
    c_start = 1'b1; c_frame_ready = 1'b1; c_out_ready = 1'b1;
    n = 0;
    while (c_done_cnt < 2 && n < 6000) begin
      tick();
      n++;
    end
    c_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("gap1_done_count", 32'(c_done_cnt), 32'd2);
    check("gap1_next_count", 32'(c_next_cnt), 32'd2);
    check("gap1_write_count", 32'(c_wr_cnt), 32'd2048);
    check("gap1_read_count", 32'(c_rd_cnt), 32'd2048);
    check("gap1_no_issue_holes", 32'(c_hole), 32'd0);
    check("gap1_wr_sequence", 32'(c_seq_err), 32'd0);
    check("gap1_idle_at_end", 32'({c_busy, c_state}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
